// File: rtl/mac_beams_ctrl_pkg.sv
// mac_beams_ctrl_pkg
//   Shared types for the beam MAC symbol sequencer: FSM state enum, the tag
//   carried alongside MAC data to predict output framing, and the helper that
//   sizes the RE counter.
package mac_beams_ctrl_pkg;

  localparam int unsigned SYM_IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic                 sop;
    logic                 eop;
    logic [SYM_IDX_W-1:0] sym_idx;
  } tag_t;

  function automatic int unsigned re_cnt_w(input int unsigned re_per_sym);
    return (re_per_sym > 1) ? $clog2(re_per_sym) : 1;
  endfunction

endpackage

// File: rtl/mac_beams_ctrl_if.sv
// mac_beams_ctrl_if
//   Bundles the RE input stream, codeword swap handshake, MAC alignment input
//   and all sequencer outputs.
//   slave  : seen by mac_beams_ctrl (inputs i_*, outputs o_*)
//   master : seen by the RE source / MAC side driving the sequencer
//   MAC_BEAMS_CTRL_STATS_EN adds o_sym_cnt / o_err_cnt.
interface mac_beams_ctrl_if #(
  parameter int unsigned DW = 2048
);
  import mac_beams_ctrl_pkg::*;

  logic [DW-1:0]        i_ants_data;
  logic                 i_rvalid;
  logic                 i_sop;
  logic                 i_cw_swap_req;
  logic                 i_mac_tvalid;

  logic [DW-1:0]        o_mac_data;
  logic                 o_mac_rvalid;
  logic                 o_cw_bank;
  logic                 o_cw_swap_ack;
  logic                 o_sop;
  logic                 o_eop;
  logic [SYM_IDX_W-1:0] o_sym_idx;
  logic                 o_slot_end;
  logic                 o_err_sop;
  logic                 o_err_align;
`ifdef MAC_BEAMS_CTRL_STATS_EN
  logic [31:0]          o_sym_cnt;
  logic [15:0]          o_err_cnt;
`endif

  modport slave (
    input  i_ants_data, i_rvalid, i_sop, i_cw_swap_req, i_mac_tvalid,
`ifdef MAC_BEAMS_CTRL_STATS_EN
    output o_sym_cnt, o_err_cnt,
`endif
    output o_mac_data, o_mac_rvalid, o_cw_bank, o_cw_swap_ack,
    output o_sop, o_eop, o_sym_idx, o_slot_end, o_err_sop, o_err_align
  );

  modport master (
    output i_ants_data, i_rvalid, i_sop, i_cw_swap_req, i_mac_tvalid,
`ifdef MAC_BEAMS_CTRL_STATS_EN
    input  o_sym_cnt, o_err_cnt,
`endif
    input  o_mac_data, o_mac_rvalid, o_cw_bank, o_cw_swap_ack,
    input  o_sop, o_eop, o_sym_idx, o_slot_end, o_err_sop, o_err_align
  );

endinterface

// File: rtl/mac_beams_ctrl_tag_delay.sv
// mac_tag_delay
//   DEPTH-stage shift register of framing tags; models the MAC pipeline so
//   sop/eop/sym_idx emerge aligned with MAC output valid.
//   i_clk, i_rst_n (async, active low), i_tag in, o_tag = i_tag delayed DEPTH.
module mac_tag_delay
  import mac_beams_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t stages [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign o_tag = stages[DEPTH-1];

endmodule

// File: rtl/mac_beams_ctrl.sv
// mac_beams_ctrl
//   Symbol sequencer in front of the beam MAC array. Frames the RE stream into
//   symbols/slots, forwards data/valid to the MAC through one register stage,
//   owns the ping-pong codeword bank (switched only at an accepted sop) and
//   predicts MAC output timing to emit sop/eop/sym_idx with MAC tvalid.
//   Ports: i_clk, i_rst_n (async active low), bus (mac_beams_ctrl_if.slave):
//     in : i_ants_data, i_rvalid, i_sop, i_cw_swap_req, i_mac_tvalid
//     out: o_mac_data, o_mac_rvalid, o_cw_bank, o_cw_swap_ack, o_sop, o_eop,
//          o_sym_idx, o_slot_end, o_err_sop, o_err_align
//   Optional MAC_BEAMS_CTRL_STATS_EN: o_sym_cnt (completed symbols, wrapping)
//   and o_err_cnt (sop + align error events, saturating).
module mac_beams_ctrl
  import mac_beams_ctrl_pkg::*;
#(
  parameter int unsigned DW           = 2048,
  parameter int unsigned RE_PER_SYM   = 3276,
  parameter int unsigned SYM_PER_SLOT = 14,
  parameter int unsigned MAC_LAT      = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  mac_beams_ctrl_if.slave bus
);

  localparam int unsigned          RE_W     = re_cnt_w(RE_PER_SYM);
  localparam logic [RE_W-1:0]      RE_LAST  = RE_W'(RE_PER_SYM - 1);
  localparam logic [SYM_IDX_W-1:0] SYM_LAST = SYM_IDX_W'(SYM_PER_SLOT - 1);

  state_t               state, state_n;
  logic [RE_W-1:0]      re_cnt, re_cnt_n;
  logic [SYM_IDX_W-1:0] sym_idx, sym_idx_n;
  logic                 pend, pend_n;
  logic                 accept, sop_tag, eop_tag, sop_err, swap;
  logic                 align_err;
  tag_t                 tag_in, tag_r, tag_out;

  logic [DW-1:0]        data_r;
  logic                 rvalid_r, bank_r, ack_r, err_sop_r, err_align_r;

  // re_cnt holds the index of the next RE expected in the current symbol.
  always_comb begin
    state_n   = state;
    re_cnt_n  = re_cnt;
    sym_idx_n = sym_idx;
    accept    = 1'b0;
    sop_tag   = 1'b0;
    eop_tag   = 1'b0;
    sop_err   = 1'b0;
    if (bus.i_rvalid) begin
      case (state)
        IDLE: begin
          if (bus.i_sop) begin
            accept   = 1'b1;
            sop_tag  = 1'b1;
            state_n  = RUN;
            re_cnt_n = RE_W'(1);
          end
        end
        RUN: begin
          accept = 1'b1;
          if (re_cnt == RE_LAST) begin
            // Last RE takes priority over a coincident sop, which is only flagged.
            eop_tag   = 1'b1;
            sop_err   = bus.i_sop;
            state_n   = IDLE;
            re_cnt_n  = '0;
            sym_idx_n = (sym_idx == SYM_LAST) ? '0 : sym_idx + SYM_IDX_W'(1);
          end else if (bus.i_sop) begin
            sop_tag  = 1'b1;
            sop_err  = 1'b1;
            re_cnt_n = RE_W'(1);
          end else begin
            re_cnt_n = re_cnt + RE_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // A request in the same cycle as the sop that consumes pending re-arms it
    // for the following symbol.
    swap   = sop_tag & pend;
    pend_n = bus.i_cw_swap_req | (pend & ~swap);

    tag_in         = '0;
    tag_in.valid   = accept;
    tag_in.sop     = sop_tag;
    tag_in.eop     = eop_tag;
    tag_in.sym_idx = accept ? sym_idx : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      re_cnt      <= '0;
      sym_idx     <= '0;
      pend        <= 1'b0;
      data_r      <= '0;
      rvalid_r    <= 1'b0;
      tag_r       <= '0;
      bank_r      <= 1'b0;
      ack_r       <= 1'b0;
      err_sop_r   <= 1'b0;
      err_align_r <= 1'b0;
    end else begin
      state       <= state_n;
      re_cnt      <= re_cnt_n;
      sym_idx     <= sym_idx_n;
      pend        <= pend_n;
      data_r      <= bus.i_ants_data;
      rvalid_r    <= accept;
      tag_r       <= tag_in;
      // Bank flips on the same edge that presents the sop RE to the MAC.
      bank_r      <= bank_r ^ swap;
      ack_r       <= swap;
      err_sop_r   <= err_sop_r | sop_err;
      err_align_r <= err_align_r | align_err;
    end
  end

  // tag_r shares timing with o_mac_rvalid; MAC_LAT more stages reach MAC tvalid.
  mac_tag_delay #(.DEPTH(MAC_LAT)) u_tag_delay (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_tag  (tag_r),
    .o_tag  (tag_out)
  );

  assign align_err = tag_out.valid ^ bus.i_mac_tvalid;

  assign bus.o_mac_data    = data_r;
  assign bus.o_mac_rvalid  = rvalid_r;
  assign bus.o_cw_bank     = bank_r;
  assign bus.o_cw_swap_ack = ack_r;
  assign bus.o_sop         = tag_out.valid & tag_out.sop;
  assign bus.o_eop         = tag_out.valid & tag_out.eop;
  assign bus.o_sym_idx     = tag_out.valid ? tag_out.sym_idx : '0;
  assign bus.o_slot_end    = tag_out.valid & tag_out.eop & (tag_out.sym_idx == SYM_LAST);
  assign bus.o_err_sop     = err_sop_r;
  assign bus.o_err_align   = err_align_r;

`ifdef MAC_BEAMS_CTRL_STATS_EN
  logic [31:0] sym_cnt;
  logic [15:0] err_cnt;
  logic [16:0] err_sum;

  // Sop and alignment errors may land in the same cycle: count both.
  assign err_sum = {1'b0, err_cnt} + {16'd0, sop_err} + {16'd0, align_err};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sym_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (eop_tag) sym_cnt <= sym_cnt + 32'd1;
      err_cnt <= err_sum[16] ? '1 : err_sum[15:0];
    end
  end

  assign bus.o_sym_cnt = sym_cnt;
  assign bus.o_err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_mac_beams_ctrl.sv
// Self-checking bench for mac_beams_ctrl with RE_PER_SYM=16, MAC_LAT=8.
// Expected outputs are kept per clock edge in arrays filled by a symbol-level
// model as stimulus is issued; a negedge process compares every cycle.
module tb_mac_beams_ctrl;
  localparam int DW  = 64;
  localparam int RE  = 16;
  localparam int SPS = 14;
  localparam int LAT = 8;
  localparam int N   = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_beams_ctrl_if #(.DW(DW)) bus ();

  mac_beams_ctrl #(
    .DW(DW), .RE_PER_SYM(RE), .SYM_PER_SLOT(SPS), .MAC_LAT(LAT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Expected values visible just after edge k (index k).
  bit            exp_rv[N], exp_bank[N], exp_ack[N], exp_esop[N], exp_ealign[N];
  bit            exp_tv[N], exp_sop[N], exp_eop[N], exp_slot[N];
  bit [3:0]      exp_idx[N];
  logic [DW-1:0] exp_data[N];
  // Observed DUT values, for literal timing checks.
  bit            act_rv[N], act_bank[N], act_ack[N], act_sop[N], act_eop[N];
  bit            act_slot[N], act_esop[N], act_ealign[N];
  bit [3:0]      act_idx[N];

  // Symbol-level model state.
  bit m_in_sym, m_pend, m_bank, m_esop, m_ealign;
  int m_pos, m_sym;
  bit late_mode = 1'b0;
  int last_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edges, act, want);
    end
  endtask

  int ce;
  always @(negedge clk) begin
    ce = edges;
    if (ce < N) begin
      act_rv[ce]     = bus.o_mac_rvalid;
      act_bank[ce]   = bus.o_cw_bank;
      act_ack[ce]    = bus.o_cw_swap_ack;
      act_sop[ce]    = bus.o_sop;
      act_eop[ce]    = bus.o_eop;
      act_slot[ce]   = bus.o_slot_end;
      act_esop[ce]   = bus.o_err_sop;
      act_ealign[ce] = bus.o_err_align;
      act_idx[ce]    = bus.o_sym_idx;
      chk("mac_rvalid", bus.o_mac_rvalid, exp_rv[ce]);
      chk("mac_data", bus.o_mac_data, exp_data[ce]);
      chk("cw_bank", bus.o_cw_bank, exp_bank[ce]);
      chk("cw_swap_ack", bus.o_cw_swap_ack, exp_ack[ce]);
      chk("sop", bus.o_sop, exp_sop[ce]);
      chk("eop", bus.o_eop, exp_eop[ce]);
      chk("sym_idx", bus.o_sym_idx, exp_idx[ce]);
      chk("slot_end", bus.o_slot_end, exp_slot[ce]);
      chk("err_sop", bus.o_err_sop, exp_esop[ce]);
      chk("err_align", bus.o_err_align, exp_ealign[ce]);
    end
  end

  // One clock of stimulus; the model predicts everything that edge implies.
  task automatic cyc(input bit rv, input bit sop, input bit req);
    logic [DW-1:0] d;
    bit acc, s, eo, ack;
    int e, t, idx;
    @(posedge clk);
    #1;
    e = edges + 1;
    if (e + LAT + 4 >= N) begin
      fails++;
      $display("FAIL edge_budget: got edge %0d, expected below %0d", e, N - LAT - 4);
      $fatal(1, "edge budget exhausted");
    end
    d = {$urandom, $urandom};
    t = late_mode ? e - 2 : e - 1;
    bus.i_ants_data   = d;
    bus.i_rvalid      = rv;
    bus.i_sop         = sop;
    bus.i_cw_swap_req = req;
    bus.i_mac_tvalid  = (t >= 0) ? exp_tv[t] : 1'b0;

    acc = 0; s = 0; eo = 0; ack = 0; idx = 0;
    if (rv && (m_in_sym || sop)) begin
      acc = 1;
      idx = m_sym;
      if (m_in_sym && m_pos == RE - 1) begin
        eo = 1;
        if (sop) m_esop = 1;
      end else if (sop) begin
        if (m_in_sym) m_esop = 1;
        s = 1;
        m_pos = 0;
      end
      m_in_sym = 1;
      m_pos++;
      if (eo) begin
        m_in_sym = 0;
        m_pos = 0;
        m_sym = (m_sym + 1) % SPS;
      end
    end
    if (s && m_pend) begin
      m_bank = !m_bank;
      ack = 1;
      m_pend = 0;
    end
    if (req) m_pend = 1;
    if (bus.i_mac_tvalid != exp_tv[e-1]) m_ealign = 1;

    exp_data[e]     = d;
    exp_rv[e]       = acc;
    exp_bank[e]     = m_bank;
    exp_ack[e]      = ack;
    exp_esop[e]     = m_esop;
    exp_ealign[e]   = m_ealign;
    exp_tv[e+LAT]   = acc;
    exp_sop[e+LAT]  = s;
    exp_eop[e+LAT]  = eo;
    exp_idx[e+LAT]  = acc ? 4'(idx) : 4'd0;
    exp_slot[e+LAT] = eo && (idx == SPS - 1);
    last_e = e;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0);
  endtask

  // 16 contiguous REs, sop on the first; optional swap requests at RE indices.
  task automatic symbol(input int req_a, input int req_b, input bit req_at_sop, output int start);
    start = 0;
    for (int i = 0; i < RE; i++) begin
      cyc(1, i == 0, (i == 0 && req_at_sop) || i == req_a || i == req_b);
      if (i == 0) start = last_e;
    end
  endtask

  task automatic do_reset(input int ncyc, output int r);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.i_rvalid = 0; bus.i_sop = 0; bus.i_cw_swap_req = 0; bus.i_mac_tvalid = 0;
    bus.i_ants_data = '0;
    r = edges;
    m_in_sym = 0; m_pos = 0; m_sym = 0; m_pend = 0; m_bank = 0;
    m_esop = 0; m_ealign = 0; late_mode = 0;
    for (int k = r; k <= r + ncyc + LAT + 4; k++) begin
      exp_rv[k] = 0; exp_bank[k] = 0; exp_ack[k] = 0; exp_esop[k] = 0;
      exp_ealign[k] = 0; exp_tv[k] = 0; exp_sop[k] = 0; exp_eop[k] = 0;
      exp_slot[k] = 0; exp_idx[k] = 0; exp_data[k] = '0;
    end
    repeat (ncyc) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int s0, sa, sb, sc, s13, sn, sm, sr, sl, sp, r, cnt;
    bit rv, sop, rq;
    bus.i_ants_data = '0; bus.i_rvalid = 0; bus.i_sop = 0;
    bus.i_cw_swap_req = 0; bus.i_mac_tvalid = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Swap request, sop three cycles later, one full symbol.
    idle(2);
    cyc(0, 0, 1);
    idle(2);
    symbol(-1, -1, 0, s0);
    idle(LAT + 6);
    chk("d1_rvalid_before", act_rv[s0-1], 0);
    chk("d1_rvalid_first", act_rv[s0], 1);
    cnt = 0;
    for (int k = s0 - 1; k < s0 + 20; k++) cnt += act_rv[k];
    chk("d1_rvalid_count", cnt, 16);
    chk("d1_sop_early", act_sop[s0+7], 0);
    chk("d1_sop_at_8", act_sop[s0+8], 1);
    chk("d1_eop_at_23", act_eop[s0+23], 1);
    chk("d1_sym_idx", act_idx[s0+8], 0);
    chk("d1_bank_before", act_bank[s0-1], 0);
    chk("d1_bank_toggle", act_bank[s0], 1);
    chk("d1_ack_pulse", act_ack[s0], 1);
    chk("d1_ack_end", act_ack[s0+1], 0);
    chk("model_sop_at_8", exp_sop[s0+8], 1);
    chk("model_eop_at_23", exp_eop[s0+23], 1);

    // Two requests merge; a request at sop applies one symbol later.
    symbol(3, 7, 0, sa);
    symbol(-1, -1, 1, sb);
    symbol(-1, -1, 0, sc);
    for (int k = 0; k < 10; k++) begin
      symbol(-1, -1, 0, s13);
    end
    symbol(-1, -1, 0, sn);
    idle(LAT + 6);
    chk("sw_no_ack_a", act_ack[sa], 0);
    chk("sw_bank_a", act_bank[sa], 1);
    chk("sw_merged_ack", act_ack[sb], 1);
    chk("sw_merged_bank", act_bank[sb], 0);
    chk("sw_next_ack", act_ack[sc], 1);
    chk("sw_next_bank", act_bank[sc], 1);
    cnt = 0;
    for (int k = sa; k < sc + RE; k++) cnt += act_ack[k];
    chk("sw_ack_count", cnt, 2);
    chk("slot_idx13", act_idx[s13+8], 13);
    chk("slot_end_pulse", act_slot[s13+23], 1);
    cnt = 0;
    for (int k = s0; k < sn + 24; k++) cnt += act_slot[k];
    chk("slot_end_count", cnt, 1);
    chk("slot_wrap_idx", act_idx[sn+8], 0);

    // Sop at RE 5 restarts the symbol.
    sm = 0; sr = 0;
    for (int i = 0; i < 21; i++) begin
      cyc(1, i == 0 || i == 5, 0);
      if (i == 0) sm = last_e;
      if (i == 5) sr = last_e;
    end
    idle(LAT + 6);
    chk("esop_before", act_esop[sr-1], 0);
    chk("esop_set", act_esop[sr], 1);
    chk("restart_sop", act_sop[sr+8], 1);
    chk("aborted_no_eop", act_eop[sm+23], 0);
    chk("restart_eop", act_eop[sr+23], 1);
    chk("restart_idx", act_idx[sr+8], 1);

    // MAC tvalid one cycle late.
    late_mode = 1'b1;
    symbol(-1, -1, 0, sl);
    idle(LAT + 10);
    late_mode = 1'b0;
    chk("align_clean", act_ealign[sl+8], 0);
    chk("align_set", act_ealign[sl+9], 1);
    chk("align_sticky", act_ealign[sl+27], 1);

    // Reset mid-symbol with bank=1 and a swap pending.
    for (int i = 0; i < 7; i++) cyc(1, i == 0, i == 2);
    do_reset(3, r);
    chk("rst_bank", act_bank[r+1], 0);
    chk("rst_rvalid", act_rv[r+1], 0);
    chk("rst_esop", act_esop[r+1], 0);
    chk("rst_ealign", act_ealign[r+1], 0);
    symbol(-1, -1, 0, sp);
    idle(LAT + 6);
    chk("post_rst_bank", act_bank[sp], 0);
    chk("post_rst_ack", act_ack[sp], 0);
    chk("post_rst_idx", act_idx[sp+8], 0);

    // Randomized traffic: gaps, stray REs, occasional mid-symbol sop, swaps.
    repeat (1500) begin
      rv  = ($urandom_range(0, 9) < 8);
      sop = m_in_sym ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0);
      rq  = ($urandom_range(0, 19) == 0);
      cyc(rv, sop, rq);
    end
    idle(LAT + 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
